ray_scheduler: RTL

Frame-level controller for the parallel ray-marching datapath. It latches the scene configuration at each frame boundary and sweeps the 640x480 pixel grid. Rays are dispatched round-robin to NUM_UNITS ray units, and shaded pixels are collected back in strict raster order. The result is a single pixel stream with regenerated sof/eol flags for the pixel packer.

---
 rtl/ray_sched_pkg.sv | 26 ++
 rtl/ray_coord_counter.sv | 53 +++++
 rtl/ray_scheduler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ray_sched_pkg.sv
// Shared types and constants for the ray scheduler: FSM states, coordinate format
// and datapath widths.
package ray_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StDispatch,
    StDrain
  } state_e;

  localparam int unsigned COORD_SHIFT   = 21;
  localparam int unsigned DEFAULT_H_RES = 640;
  localparam int unsigned DEFAULT_V_RES = 480;

  // Raster index width; an index of up to 2047 still fits 32 bits after the shift.
  localparam int unsigned COORD_W  = 11;
  localparam int unsigned QCOORD_W = 32;
  localparam int unsigned COLOR_W  = 24;
  localparam int unsigned VEC_W    = 96;

  function automatic logic [QCOORD_W-1:0] to_q824(logic [COORD_W-1:0] idx);
    return QCOORD_W'(idx) << COORD_SHIFT;
  endfunction

endpackage

// File: rtl/ray_coord_counter.sv
// Raster-order (x,y) counter with synchronous clear and step enable; flags the last
// column of a line and the last pixel of a frame.
module ray_coord_counter
  import ray_sched_pkg::*;
#(
  parameter int unsigned H_RES = DEFAULT_H_RES,
  parameter int unsigned V_RES = DEFAULT_V_RES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               step,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last_x,
  output logic               last_frame
);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  assign x          = x_q;
  assign y          = y_q;
  assign last_x     = (x_q == COORD_W'(H_RES - 1));
  assign last_frame = last_x && (y_q == COORD_W'(V_RES - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (step) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_frame ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/ray_scheduler.sv
// Frame controller: latches scene config, dispatches rays round-robin, collects results
// in raster order. Define CONTINUOUS_EN to chain frames back-to-back after one start.
module ray_scheduler
  import ray_sched_pkg::*;
#(
  parameter int unsigned NUM_UNITS       = 4,
  parameter int unsigned H_RES           = DEFAULT_H_RES,
  parameter int unsigned V_RES           = DEFAULT_V_RES,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [VEC_W-1:0]             light_pos,
  input  logic [VEC_W-1:0]             camera_forward,
  input  logic [VEC_W-1:0]             camera_right,
  input  logic [VEC_W-1:0]             ray_origin,
  input  logic                         sdf_sel,
  output logic [VEC_W-1:0]             cfg_light_pos,
  output logic [VEC_W-1:0]             cfg_camera_forward,
  output logic [VEC_W-1:0]             cfg_camera_right,
  output logic [VEC_W-1:0]             cfg_ray_origin,
  output logic                         cfg_sdf_sel,
  output logic [NUM_UNITS-1:0]         disp_valid,
  input  logic [NUM_UNITS-1:0]         disp_ready,
  output logic [QCOORD_W-1:0]          disp_x,
  output logic [QCOORD_W-1:0]          disp_y,
  input  logic [NUM_UNITS-1:0]         res_valid,
  input  logic [COLOR_W*NUM_UNITS-1:0] res_data,
  output logic [NUM_UNITS-1:0]         res_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COLOR_W-1:0]           out_pixel,
  output logic                         out_sof,
  output logic                         out_eol,
  output logic                         busy,
  output logic                         frame_done,
  output logic [15:0]                  frame_count
);

  localparam int unsigned PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  function automatic logic [NUM_UNITS-1:0] unit_sel(logic [PTR_W-1:0] p);
    return NUM_UNITS'(1) << p;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_UNITS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  state_e               state_q, state_d;
  logic [VEC_W-1:0]     light_q, fwd_q, right_q, origin_q;
  logic                 sdf_q;
  logic [NUM_UNITS-1:0] disp_valid_q, disp_valid_d;
  logic [PTR_W-1:0]     disp_ptr_q, disp_ptr_d;
  logic [PTR_W-1:0]     coll_ptr_q, coll_ptr_d;
  logic [OUT_W-1:0]     outstanding_q, outstanding_d;
  logic                 out_valid_q, out_valid_d;
  logic [COLOR_W-1:0]   out_pixel_q, out_pixel_d;
  logic                 out_sof_q, out_sof_d;
  logic                 out_eol_q, out_eol_d;
  logic                 out_last_q, out_last_d;
  logic                 frame_done_q, frame_done_d;
  logic [15:0]          frame_count_q, frame_count_d;

  logic                 cfg_load, cnt_clear;
  logic                 collecting, disp_fire, coll_fire, out_fire;
  logic [COORD_W-1:0]   dsp_x, dsp_y, col_x, col_y;
  logic                 dsp_last_x, dsp_last_frame, col_last_x, col_last_frame;

  ray_coord_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_disp_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .step       (disp_fire),
    .x          (dsp_x),
    .y          (dsp_y),
    .last_x     (dsp_last_x),
    .last_frame (dsp_last_frame)
  );

  ray_coord_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_coll_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .step       (coll_fire),
    .x          (col_x),
    .y          (col_y),
    .last_x     (col_last_x),
    .last_frame (col_last_frame)
  );

  assign collecting = (state_q == StDispatch) || (state_q == StDrain);
  // Only the unit holding the next raster pixel may hand over a result.
  assign res_ready  = (collecting && (!out_valid_q || out_ready)) ? unit_sel(coll_ptr_q) : '0;
  assign coll_fire  = |(res_ready & res_valid);
  assign disp_fire  = |(disp_valid_q & disp_ready);
  assign out_fire   = out_valid_q && out_ready;

  always_comb begin
    state_d       = state_q;
    disp_valid_d  = disp_valid_q;
    disp_ptr_d    = disp_ptr_q;
    coll_ptr_d    = coll_ptr_q;
    outstanding_d = outstanding_q + OUT_W'(disp_fire) - OUT_W'(coll_fire);
    out_valid_d   = out_valid_q;
    out_pixel_d   = out_pixel_q;
    out_sof_d     = out_sof_q;
    out_eol_d     = out_eol_q;
    out_last_d    = out_last_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    cfg_load      = 1'b0;
    cnt_clear     = 1'b0;

    if (coll_fire) begin
      out_valid_d = 1'b1;
      out_pixel_d = res_data[int'(coll_ptr_q)*COLOR_W +: COLOR_W];
      out_sof_d   = (col_x == '0) && (col_y == '0);
      out_eol_d   = col_last_x;
      out_last_d  = col_last_frame;
      coll_ptr_d  = ptr_next(coll_ptr_q);
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLatch;
      end
      StLatch: begin
        cfg_load      = 1'b1;
        cnt_clear     = 1'b1;
        disp_ptr_d    = '0;
        coll_ptr_d    = '0;
        outstanding_d = '0;
        disp_valid_d  = unit_sel('0);
        state_d       = StDispatch;
      end
      StDispatch: begin
        if (disp_fire) begin
          disp_ptr_d = ptr_next(disp_ptr_q);
          if (dsp_last_x && dsp_last_frame) begin
            disp_valid_d = '0;
            state_d      = StDrain;
          end else begin
            disp_valid_d = (outstanding_d < OUT_W'(MAX_OUTSTANDING)) ? unit_sel(disp_ptr_d) : '0;
          end
        end else if (disp_valid_q == '0 && outstanding_d < OUT_W'(MAX_OUTSTANDING)) begin
          // Request is raised a cycle after a collection frees a slot, never in the same cycle.
          disp_valid_d = unit_sel(disp_ptr_q);
        end
      end
      StDrain: begin
        if (out_fire && out_last_q && outstanding_q == '0) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
`ifdef CONTINUOUS_EN
          state_d       = StLatch;
`else
          state_d       = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      light_q       <= '0;
      fwd_q         <= '0;
      right_q       <= '0;
      origin_q      <= '0;
      sdf_q         <= 1'b0;
      disp_valid_q  <= '0;
      disp_ptr_q    <= '0;
      coll_ptr_q    <= '0;
      outstanding_q <= '0;
      out_valid_q   <= 1'b0;
      out_pixel_q   <= '0;
      out_sof_q     <= 1'b0;
      out_eol_q     <= 1'b0;
      out_last_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      disp_valid_q  <= disp_valid_d;
      disp_ptr_q    <= disp_ptr_d;
      coll_ptr_q    <= coll_ptr_d;
      outstanding_q <= outstanding_d;
      out_valid_q   <= out_valid_d;
      out_pixel_q   <= out_pixel_d;
      out_sof_q     <= out_sof_d;
      out_eol_q     <= out_eol_d;
      out_last_q    <= out_last_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      if (cfg_load) begin
        light_q  <= light_pos;
        fwd_q    <= camera_forward;
        right_q  <= camera_right;
        origin_q <= ray_origin;
        sdf_q    <= sdf_sel;
      end
    end
  end

  assign cfg_light_pos      = light_q;
  assign cfg_camera_forward = fwd_q;
  assign cfg_camera_right   = right_q;
  assign cfg_ray_origin     = origin_q;
  assign cfg_sdf_sel        = sdf_q;
  assign disp_valid         = disp_valid_q;
  assign disp_x             = to_q824(dsp_x);
  assign disp_y             = to_q824(dsp_y);
  assign out_valid          = out_valid_q;
  assign out_pixel          = out_pixel_q;
  assign out_sof            = out_sof_q;
  assign out_eol            = out_eol_q;
  assign busy               = (state_q != StIdle);
  assign frame_done         = frame_done_q;
  assign frame_count        = frame_count_q;

endmodule
